// File: rtl/ahb_master_burst_ctrl_pkg.sv
// Shared AHB types and controller state encoding for the master burst engine.
package AHB_package;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } burst_type;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } trans_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_BURST,
    ST_DRAIN
  } ctrl_state_t;

  // Number of address phases in a burst; len is only meaningful for INCR.
  function automatic logic [4:0] burst_beats(input burst_type b, input logic [3:0] len);
    case (b)
      INCR:          return {1'b0, len} + 5'd1;
      WRAP4, INCR4:  return 5'd4;
      WRAP8, INCR8:  return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:       return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_master_burst_ctrl_if.sv
// AHB master-side bus signals including the per-slave request/grant pair.
interface ahb_master_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  import AHB_package::*;

  logic                  hreq;
  logic                  hgrant;
  logic                  hwait;
  logic [ADDR_WIDTH-1:0] haddr;
  trans_type             htrans;
  logic                  hwrite;
  burst_type             hburst;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hreq, haddr, htrans, hwrite, hburst, hsize, hwdata,
    input  hgrant, hwait, hrdata
  );

  modport slave (
    input  hreq, haddr, htrans, hwrite, hburst, hsize, hwdata,
    output hgrant, hwait, hrdata
  );

endinterface

// File: rtl/ahb_master_burst_ctrl_addr_gen.sv
// Combinational next-beat address for INCR and WRAP bursts.
module ahb_burst_addr_gen
  import AHB_package::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  input  burst_type             burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] mask;

  // Non-wrapping bursts use an all-ones mask, so the merge collapses to addr+inc.
  always_comb begin
    inc       = ADDR_WIDTH'(1) << size_i;
    incr_addr = addr_i + inc;
    case (burst_i)
      WRAP4:   mask = (inc << 2) - ADDR_WIDTH'(1);
      WRAP8:   mask = (inc << 3) - ADDR_WIDTH'(1);
      WRAP16:  mask = (inc << 4) - ADDR_WIDTH'(1);
      default: mask = '1;
    endcase
    next_addr_o = (addr_i & ~mask) | (incr_addr & mask);
  end

endmodule

// File: rtl/ahb_master_burst_ctrl.sv
// AHB master burst engine: takes one client command, requests the bus and
// issues every address phase of the burst while tracking the pipelined data phase.
module ahb_master_burst_ctrl
  import AHB_package::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  burst_type             cmd_burst,
  input  logic [3:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  ahb_master_burst_ctrl_if.master bus
);

  ctrl_state_t           state_q;
  logic                  hreq_q;
  trans_type             htrans_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  burst_type             hburst_q;
  logic [2:0]            hsize_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic [4:0]            remain_q;
  logic                  dpend_q;

  logic                  addr_phase;
  logic                  accept;
  logic                  data_done;
  logic [ADDR_WIDTH-1:0] haddr_d;

  ahb_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr_i      (haddr_q),
    .size_i      (hsize_q),
    .burst_i     (hburst_q),
    .next_addr_o (haddr_d)
  );

  // hgrant arrives already gated by ~hwait, so an accept also implies the
  // previous data phase completes on the same edge.
  assign addr_phase  = (state_q == ST_REQ) || (state_q == ST_BURST);
  assign accept      = addr_phase && bus.hgrant;
  assign data_done   = dpend_q && !bus.hwait;

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wdata_ready = accept && hwrite_q;
  assign rdata_valid = data_done && !hwrite_q;
  assign rdata       = rdata_valid ? bus.hrdata : '0;

  assign bus.hreq    = hreq_q;
  assign bus.htrans  = htrans_q;
  assign bus.haddr   = haddr_q;
  assign bus.hwrite  = hwrite_q;
  assign bus.hburst  = hburst_q;
  assign bus.hsize   = hsize_q;
  assign bus.hwdata  = hwdata_q;

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q  <= ST_IDLE;
      hreq_q   <= 1'b0;
      htrans_q <= IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hburst_q <= SINGLE;
      hsize_q  <= '0;
      hwdata_q <= '0;
      remain_q <= '0;
      dpend_q  <= 1'b0;
    end else begin
      dpend_q <= accept || (dpend_q && bus.hwait);
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q  <= ST_REQ;
            hreq_q   <= 1'b1;
            htrans_q <= NONSEQ;
            haddr_q  <= cmd_addr;
            hwrite_q <= cmd_write;
            hburst_q <= cmd_burst;
            hsize_q  <= cmd_size;
            remain_q <= burst_beats(cmd_burst, cmd_len);
          end
        end
        ST_REQ, ST_BURST: begin
          if (bus.hgrant) begin
            if (hwrite_q) hwdata_q <= wdata;
            remain_q <= remain_q - 5'd1;
            if (remain_q == 5'd1) begin
              state_q  <= ST_DRAIN;
              hreq_q   <= 1'b0;
              htrans_q <= IDLE;
            end else begin
              state_q  <= ST_BURST;
              htrans_q <= SEQ;
              haddr_q  <= haddr_d;
            end
          end
        end
        ST_DRAIN: begin
          if (data_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_burst_ctrl.sv
// Self-checking bench: directed and random bursts against a transaction-level model.
module tb_ahb_master_burst_ctrl;
  import AHB_package::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  burst_type     cmd_burst;
  logic [3:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic          cmd_write;
  logic [DW-1:0] wdata;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;

  always #5 hclk = ~hclk;

  ahb_master_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_master_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .hclk        (hclk),
    .hreset_n    (hreset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_burst   (cmd_burst),
    .cmd_len     (cmd_len),
    .cmd_size    (cmd_size),
    .cmd_write   (cmd_write),
    .wdata       (wdata),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .bus         (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_hreq"},        bus.hreq,    0);
    check_eq({tag, "_htrans"},      bus.htrans,  IDLE);
    check_eq({tag, "_haddr"},       bus.haddr,   0);
    check_eq({tag, "_hwrite"},      bus.hwrite,  0);
    check_eq({tag, "_hburst"},      bus.hburst,  SINGLE);
    check_eq({tag, "_hsize"},       bus.hsize,   0);
    check_eq({tag, "_hwdata"},      bus.hwdata,  0);
    check_eq({tag, "_wdata_ready"}, wdata_ready, 0);
    check_eq({tag, "_rdata_valid"}, rdata_valid, 0);
    check_eq({tag, "_rdata"},       rdata,       0);
    check_eq({tag, "_cmd_ready"},   cmd_ready,   1);
  endtask

  function automatic int model_beats(input burst_type b, input logic [3:0] len);
    if (b == SINGLE) return 1;
    if (b == INCR) return int'(len) + 1;
    if (b == WRAP4 || b == INCR4) return 4;
    if (b == WRAP8 || b == INCR8) return 8;
    return 16;
  endfunction

  // Drives one command and acts as arbiter+slave; every address, data and pulse
  // is checked against a closed-form list of expected beats.
  task automatic run_cmd(input burst_type b, input logic [31:0] a0, input logic [3:0] len,
                         input logic [2:0] size, input logic wr, input bit stall,
                         input int wait_at, input int wait_len);
    int n, ai, dn, nwr, wcnt;
    longint unsigned inc, span, base, a;
    logic [31:0] ea[$];
    logic [31:0] wq[$];
    bit pend, done, ok, acc, wt, gr, dir, exp_rv;
    n = model_beats(b, len);
    inc = longint'(1) << size;
    span = inc * longint'(n);
    base = longint'(a0) - (longint'(a0) % span);
    for (int i = 0; i < n; i++) begin
      if (b == WRAP4 || b == WRAP8 || b == WRAP16)
        a = base + ((longint'(a0) - base + longint'(i) * inc) % span);
      else
        a = (longint'(a0) + longint'(i) * inc) % 64'h1_0000_0000;
      ea.push_back(a[31:0]);
    end
    ai = 0; dn = 0; nwr = 0; wcnt = 0;
    pend = 0; done = 0; ok = 0;

    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = a0; cmd_burst = b; cmd_len = len;
    cmd_size = size; cmd_write = wr;
    bus.hgrant = 1'b0; bus.hwait = 1'b0;
    #1 check_eq("cmd_ready_idle", cmd_ready, 1);

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge hclk);
      cmd_valid = 1'b0;
      dir = (ai == wait_at) && (wcnt < wait_len) && pend;
      if (dir) wcnt++;
      wt = pend && (dir || (stall && $urandom_range(0, 3) == 0));
      gr = bus.hreq && !wt && (!stall || $urandom_range(0, 4) != 0);
      bus.hwait  = wt;
      bus.hgrant = gr;
      bus.hrdata = $urandom;
      wdata      = $urandom;
      #1;
      check_eq("cmd_ready", cmd_ready, done);
      if (done) begin ok = 1; break; end

      exp_rv = pend && !wt && !wr;
      check_eq("rdata_valid", rdata_valid, exp_rv);
      if (exp_rv) check_eq("rdata", rdata, bus.hrdata);
      if (pend && wr) check_eq("hwdata", bus.hwdata, wq[0]);
      if (pend && !wt) begin
        if (wr) void'(wq.pop_front());
        dn++;
      end

      acc = 0;
      if (ai < n) begin
        check_eq("hreq", bus.hreq, 1);
        check_eq("htrans", bus.htrans, (ai == 0) ? NONSEQ : SEQ);
        check_eq("haddr", bus.haddr, ea[ai]);
        check_eq("hwrite", bus.hwrite, wr);
        check_eq("hburst", bus.hburst, b);
        check_eq("hsize", bus.hsize, size);
        acc = gr;
      end else begin
        check_eq("hreq_done", bus.hreq, 0);
        check_eq("htrans_done", bus.htrans, IDLE);
      end
      check_eq("wdata_ready", wdata_ready, acc && wr);
      if (wdata_ready) nwr++;
      if (acc) begin
        if (wr) wq.push_back(wdata);
        ai++;
      end
      pend = acc || (pend && wt);
      if (dn == n) done = 1;
    end
    if (!ok) check_eq("timeout", 0, 1);
    check_eq("addr_beats", ai, n);
    check_eq("data_beats", dn, n);
    check_eq("wdata_pulses", nwr, wr ? n : 0);
  endtask

  initial begin
    burst_type rb;
    logic [31:0] ra;
    logic [2:0]  rs;

    hreset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = SINGLE;
    cmd_len = '0; cmd_size = '0; cmd_write = 1'b0; wdata = '0;
    bus.hgrant = 1'b0; bus.hwait = 1'b0; bus.hrdata = '0;
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    #1 check_reset_vals("reset");
    hreset_n = 1'b1;

    run_cmd(SINGLE, 32'h0000_0100, 4'd0, 3'd2, 1'b1, 0, -1, 0);
    run_cmd(INCR4,  32'h0000_0200, 4'd0, 3'd2, 1'b0, 0, -1, 0);
    run_cmd(WRAP8,  32'h0000_0034, 4'd0, 3'd2, 1'b0, 0, -1, 0);
    run_cmd(INCR8,  32'h0000_0400, 4'd0, 3'd2, 1'b1, 0, 2, 2);
    run_cmd(INCR,   32'hFFFF_FFF8, 4'd2, 3'd2, 1'b0, 0, -1, 0);
    run_cmd(WRAP16, 32'h0000_1006, 4'd0, 3'd1, 1'b1, 1, -1, 0);

    for (int k = 0; k < 12; k++) begin
      rb = burst_type'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 2));
      ra = $urandom;
      ra = (ra >> rs) << rs;
      run_cmd(rb, ra, 4'($urandom_range(0, 15)), rs, 1'($urandom_range(0, 1)), 1, -1, 0);
    end

    // Reset while beat 5 of an INCR16 write is in its address phase.
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = 32'h0000_2000; cmd_burst = INCR16;
    cmd_len = '0; cmd_size = 3'd2; cmd_write = 1'b1;
    bus.hgrant = 1'b0; bus.hwait = 1'b0;
    @(negedge hclk);
    cmd_valid = 1'b0; bus.hgrant = 1'b1;
    repeat (4) @(negedge hclk);
    #1 check_eq("midrst_haddr_before", bus.haddr, 32'h0000_2010);
    hreset_n = 1'b0;
    @(negedge hclk);
    #1 check_reset_vals("midrst");
    hreset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge hclk);
      bus.hgrant = bus.hreq;
      bus.hwait  = 1'b0;
      #1;
      check_eq("post_rst_wdata_ready", wdata_ready, 0);
      check_eq("post_rst_rdata_valid", rdata_valid, 0);
      check_eq("post_rst_hreq", bus.hreq, 0);
      check_eq("post_rst_cmd_ready", cmd_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
